// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
// APB initiator. Each command accepted on the valid/ready command port becomes
// one APB SETUP+ACCESS transfer. The result comes back on a valid/ready response
// port. PREADY wait states and PSLVERR are honoured. A watchdog aborts a
// transfer whose slave holds PREADY low for TIMEOUT consecutive ACCESS cycles.
//
// Ports
//   PCLK, PRESET          clock (rising edge); asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write/cmd_addr/cmd_wdata payload
//   rsp_valid/rsp_ready   response handshake; rsp_rdata/rsp_err/rsp_timeout payload
//   PADDR..PWDATA         APB request outputs, all registered
//   PRDATA/PREADY/PSLVERR APB completion inputs from the slave
// -----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A zero TIMEOUT still needs a legal one-bit counter; it is never compared.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WD_W-1:0]   wd_inc_s;
    logic              timeout_hit_s;

    // The watchdog saturates, so a hung slave with TIMEOUT=0 never wraps it.
    assign wd_inc_s      = (wd_q == {WD_W{1'b1}}) ? wd_q : (wd_q + {{(WD_W-1){1'b0}}, 1'b1});
    assign timeout_hit_s = (TIMEOUT != 0) && (wd_inc_s == WD_LIMIT);

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = cmd_valid ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = (PREADY || timeout_hit_s) ? ST_RESP : ST_ACCESS;
            ST_RESP:   state_d = rsp_ready ? ST_IDLE : ST_RESP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered APB and response outputs.
    always_comb begin
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_d          = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                end else begin
                    psel_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                wd_d      = '0;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                end else begin
                    wd_d = wd_inc_s;
                    if (timeout_hit_s) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                    end else begin
                        rsp_valid_d   = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and watchdog.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_q          <= wd_d;
        end
    end

    // Command acceptance depends on state alone so it never combinationally
    // follows cmd_valid.
    assign cmd_ready   = (state_q == ST_IDLE);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
